// File: rtl/led_pkg.sv
// Shared mode and direction encodings for the LED pattern/PWM driver.
package led_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_ON     = 2'd0;
  localparam logic [MODE_W-1:0] MODE_BLINK  = 2'd1;
  localparam logic [MODE_W-1:0] MODE_CHASE  = 2'd2;
  localparam logic [MODE_W-1:0] MODE_BOUNCE = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate prescaler: counts 0..DIV-1 and flags the last count as tick.
module led_tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/led_pattern_pwm.sv
// LED driver with global PWM brightness and ON/BLINK/CHASE/BOUNCE patterns.
module led_pattern_pwm
  import led_pkg::*;
#(
  parameter int unsigned N_LEDS   = 4,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned CLK_HZ   = 25000000,
  parameter int unsigned STEP_HZ  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [MODE_W-1:0]   cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_bright,
  output logic [N_LEDS-1:0]   led,
  output logic                step
);

  localparam int unsigned DIV = CLK_HZ / STEP_HZ;
  localparam logic [N_LEDS-1:0] LED_BIT0 = N_LEDS'(1);
  localparam logic [N_LEDS-1:0] LED_MSB  = LED_BIT0 << (N_LEDS - 1);

  logic [MODE_W-1:0]   mode;
  logic [PWM_BITS-1:0] bright;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [N_LEDS-1:0]   pattern;
  logic [N_LEDS-1:0]   pattern_nxt;
  logic [N_LEDS-1:0]   mask;
  logic                dir;
  logic                dir_nxt;
  logic                phase;
  logic                tick;
  logic                on;

  led_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (cfg_w_clr()),
    .tick (tick)
  );

  function automatic logic cfg_w_clr();
    return cfg_we;
  endfunction

  // Next pattern/direction applied on a tick; a single LED never moves.
  always_comb begin
    pattern_nxt = pattern;
    dir_nxt     = dir;
    case (mode)
      MODE_CHASE: begin
        pattern_nxt = (pattern << 1) | (pattern >> (N_LEDS - 1));
      end
      MODE_BOUNCE: begin
        if (N_LEDS > 1) begin
          if (dir == DIR_UP) begin
            pattern_nxt = pattern << 1;
            if (pattern_nxt == LED_MSB) dir_nxt = DIR_DOWN;
          end else begin
            pattern_nxt = pattern >> 1;
            if (pattern_nxt == LED_BIT0) dir_nxt = DIR_UP;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    mask = pattern;
    case (mode)
      MODE_ON:    mask = '1;
      MODE_BLINK: mask = phase ? '1 : '0;
      default:    mask = pattern;
    endcase
  end

  // Full-scale brightness is forced on so the legacy "all on" is steady.
  assign on = (pwm_cnt < bright) || (bright == '1);

  // A config write resyncs the pattern and swallows a coincident tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      led     <= '0;
      step    <= 1'b0;
      mode    <= MODE_ON;
      bright  <= '1;
      pattern <= LED_BIT0;
      dir     <= DIR_UP;
      phase   <= 1'b1;
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      led     <= mask & {N_LEDS{on}};
      if (cfg_we) begin
        mode    <= cfg_mode;
        bright  <= cfg_bright;
        pattern <= LED_BIT0;
        dir     <= DIR_UP;
        phase   <= 1'b1;
        step    <= 1'b0;
      end else begin
        step <= tick;
        if (tick) begin
          pattern <= pattern_nxt;
          dir     <= dir_nxt;
          if (mode == MODE_BLINK) phase <= ~phase;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_pwm.sv
// Directed self-checking bench for led_pattern_pwm (N_LEDS=4, PWM_BITS=3, DIV=4).
module tb_led_pattern_pwm;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [1:0] cfg_mode;
  logic [2:0] cfg_bright;
  logic [3:0] led;
  logic       step;

  int n_cmp = 0;
  int n_err = 0;

  led_pattern_pwm #(
    .N_LEDS   (4),
    .PWM_BITS (3),
    .CLK_HZ   (16),
    .STEP_HZ  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_mode   (cfg_mode),
    .cfg_bright (cfg_bright),
    .led        (led),
    .step       (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_cfg(input logic [1:0] m, input logic [2:0] b);
    cfg_we     = 1'b1;
    cfg_mode   = m;
    cfg_bright = b;
    cyc();
    cfg_we = 1'b0;
  endtask

  logic [3:0] chase_seq  [5];
  logic [3:0] bounce_seq [8];
  int         lit_cnt;

  initial begin
    chase_seq  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bounce_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                   4'b0100, 4'b0010, 4'b0001, 4'b0010};
    rst        = 1'b1;
    cfg_we     = 1'b0;
    cfg_mode   = 2'd0;
    cfg_bright = 3'd0;

    // Reset
    cyc();
    cyc();
    chk("reset_led", 32'(led), 32'h0);
    chk("reset_step", 32'(step), 32'h0);
    rst = 1'b0;

    // Default after release: all on, step every 4th cycle
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("default_led", 32'(led), 32'hF);
      chk("default_step", 32'(step), ((i % 4) == 3) ? 32'h1 : 32'h0);
    end

    // CHASE, full brightness
    write_cfg(2'd2, 3'd7);
    chk("chase_wr_step", 32'(step), 32'h0);
    chk("chase_wr_led_old", 32'(led), 32'hF);
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk("chase_led", 32'(led), 32'(chase_seq[k / 4]));
      chk("chase_step", 32'(step), ((k % 4) == 3) ? 32'h1 : 32'h0);
    end

    // BOUNCE, full brightness
    write_cfg(2'd3, 3'd7);
    for (int k = 0; k < 32; k++) begin
      cyc();
      chk("bounce_led", 32'(led), 32'(bounce_seq[k / 4]));
      chk("bounce_step", 32'(step), ((k % 4) == 3) ? 32'h1 : 32'h0);
    end

    // ON, bright=3: 3 of every 8 cycles lit
    write_cfg(2'd0, 3'd3);
    lit_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (led == 4'hF) lit_cnt++;
      chk("on3_led_allornone", 32'((led == 4'hF) || (led == 4'h0)), 32'h1);
    end
    chk("on3_lit_count", 32'(lit_cnt), 32'd3);

    // ON, bright=0: never lit
    write_cfg(2'd0, 3'd0);
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("on0_led", 32'(led), 32'h0);
    end

    // BLINK, full brightness: 4 on, 4 off
    write_cfg(2'd1, 3'd7);
    for (int k = 0; k < 15; k++) begin
      cyc();
      chk("blink_led", 32'(led), (((k / 4) % 2) == 0) ? 32'hF : 32'h0);
    end

    // Write lands on a tick cycle: step swallowed, phase restarts at 1
    write_cfg(2'd1, 3'd7);
    chk("blink_tickwr_step", 32'(step), 32'h0);
    chk("blink_tickwr_led_old", 32'(led), 32'h0);
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("blink_resync_led", 32'(led), (k < 4) ? 32'hF : 32'h0);
      chk("blink_resync_step", 32'(step), ((k % 4) == 3) ? 32'h1 : 32'h0);
    end

    // Reset mid-CHASE while led=0100
    write_cfg(2'd2, 3'd7);
    for (int k = 0; k < 9; k++) cyc();
    chk("midrst_pre_led", 32'(led), 32'h4);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_led", 32'(led), 32'h0);
    chk("midrst_step", 32'(step), 32'h0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("post_rst_led", 32'(led), 32'hF);
      chk("post_rst_step", 32'(step), (k == 3) ? 32'h1 : 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_pattern_pwm.md
Name: led_pattern_pwm

Overview:
Parametrised successor to the go-board static "all LEDs on" driver. Drives N_LEDS outputs with global PWM brightness and one of four runtime-selectable patterns: all-on, blink, chase, bounce. Sits between top-level board pins and any control logic that selects the mode. After reset, with no writes, it reproduces the legacy "all LEDs on" behaviour.

Parameters:
N_LEDS, 4, number of LED outputs (>=1)
PWM_BITS, 8, brightness/PWM counter width (>=1)
CLK_HZ, 25000000, clk frequency in Hz
STEP_HZ, 4, pattern step rate in Hz; DIV = CLK_HZ/STEP_HZ (integer division), must be >=2

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
cfg_we  in  1  single-cycle write strobe for mode/brightness
cfg_mode  in  2  pattern: 0 ON, 1 BLINK, 2 CHASE, 3 BOUNCE
cfg_bright  in  PWM_BITS  duty value
led  out  N_LEDS  registered LED drive, 1 = lit
step  out  1  one-cycle pulse, high on the cycle a pattern step is applied

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-high, and overrides cfg_we. While rst is high at a clock edge, the following take their reset values at that edge:
  - Outputs: led=0, step=0.
  - Configuration: mode=ON, bright=all ones.
  - Pattern state: pattern=one-hot bit0, dir=UP, phase=1.
  - Counters: prescaler=0, pwm_cnt=0.
- Prescaler: counts 0..DIV-1 and wraps to 0. tick=1 combinationally when prescaler==DIV-1. step is tick registered one cycle.
- PWM: pwm_cnt is a free-running PWM_BITS counter that wraps 2^PWM_BITS-1 -> 0.
  - on = (pwm_cnt < bright) OR (bright == all ones).
  - bright=0 means never lit. bright=max means always lit.
- Pattern state updates on edges where tick=1:
  - ON: no state change.
  - BLINK: phase toggles.
  - CHASE: pattern rotates left by 1; the MSB wraps to bit0.
  - BOUNCE, dir=UP: shift left. If the new pattern is the MSB, dir becomes DOWN.
  - BOUNCE, dir=DOWN: shift right. If the new pattern is bit0, dir becomes UP.
  - N_LEDS=1: pattern stays bit0 in CHASE and BOUNCE; dir stays UP.
- Output (registered, 1-cycle latency from the current state): led <= mask & {N_LEDS{on}}, where mask is:
  - ON: all ones.
  - BLINK: all ones if phase=1, else all zeros.
  - CHASE and BOUNCE: pattern.
- Config write: when cfg_we=1 and rst=0 at an edge:
  - mode and bright are latched.
  - pattern=bit0, dir=UP, phase=1, prescaler=0.
  - pwm_cnt is NOT reset.
  - The write has priority over a simultaneous tick: the step is discarded and step is 0 the next cycle.
  - led reflects the new config from the 2nd cycle after the cfg_we cycle.
- Writing the same mode again still restarts the pattern (deterministic resync).
- Reset mid-pattern: all state returns to reset values. The pattern restarts at bit0 after release.

Decomposition:
- Package led_pkg: mode localparams MODE_ON=2'd0, MODE_BLINK=2'd1, MODE_CHASE=2'd2, MODE_BOUNCE=2'd3; DIR_UP/DIR_DOWN constants; mode width constant 2.
- Sub-module led_tick_gen (params DIV; ports clk, rst, clr, tick): the prescaler. clr is driven by cfg_we.
- Everything else stays in led_pattern_pwm.

Test Plan (all scenarios use N_LEDS=4, PWM_BITS=3, CLK_HZ=16, STEP_HZ=4, so DIV=4):
- Reset then no writes -> led=4'b0000 during reset; led=4'b1111 constantly from the 1st cycle after release; step pulses every 4 cycles.
- Write CHASE with bright=7 -> led is 0001, 0010, 0100, 1000, 0001, each held 4 cycles, advancing the cycle after each step pulse.
- Write BOUNCE with bright=7 -> led sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, 4 cycles each.
- Write ON with bright=3 -> over any 8 consecutive cycles, led=1111 exactly 3 cycles and 0000 for the other 5; bright=0 -> led=0000 always.
- Write BLINK with bright=7 -> led is 1111 for 4 cycles, then 0000 for 4 cycles, repeating; cfg_we issued on a tick cycle -> step=0 next cycle, and phase restarts at 1.
- Assert rst for 1 cycle mid-CHASE while led=0100 -> led=0000 the cycle after the rst edge, then 1111 (mode ON) from the following cycle.
